// File: rtl/track_if.sv
// Signal bundle between the video timing/detector side and the tracking controller.
interface track_if;
  logic        vs;
  logic        btn_extract;
  logic        btn_clear;
  logic [11:0] center_h;
  logic [11:0] center_v;
  logic        sw_extract;
  logic        sw_clear;
  logic [11:0] track_h;
  logic [11:0] track_v;
  logic        track_valid;
  logic [2:0]  state_o;

  modport master (
    output vs, btn_extract, btn_clear, center_h, center_v,
    input  sw_extract, sw_clear, track_h, track_v, track_valid, state_o
  );

  modport slave (
    input  vs, btn_extract, btn_clear, center_h, center_v,
    output sw_extract, sw_clear, track_h, track_v, track_valid, state_o
  );
endinterface

// File: rtl/track_ctrl.sv
// Colour-tracking sequencer: debounced buttons arm learning/clearing on frame boundaries,
// and the per-frame object centre is smoothed into track_h/track_v.
module track_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned LOST_FRAMES  = 8,
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned V_ACTIVE     = 720
) (
  input logic    video_clk,
  input logic    rst_n,
  track_if.slave bus
);

  localparam int unsigned DbW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StLearn = 3'd2,
    StTrack = 3'd3,
    StLost  = 3'd4,
    StClear = 3'd5
  } state_e;

  // Bit 0 = extract, bit 1 = clear.
  logic [1:0]          btn_raw;
  logic [1:0]          sync0_q, sync1_q, stable_q;
  logic [1:0][DbW-1:0] db_cnt_q;
  logic [1:0]          press;

  assign btn_raw = {bus.btn_clear, bus.btn_extract};

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q  <= '0;
      sync1_q  <= '0;
      stable_q <= '0;
      db_cnt_q <= '0;
    end else begin
      sync0_q <= btn_raw;
      sync1_q <= sync0_q;
      for (int i = 0; i < 2; i++) begin
        if (sync1_q[i] != stable_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            stable_q[i] <= sync1_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Press fires on the same edge the stable level is accepted as 1.
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = sync1_q[i] & ~stable_q[i] & (db_cnt_q[i] == DbLast);
    end
  end

  logic vs_q;
  logic fb;
  logic found;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b0;
    else        vs_q <= bus.vs;
  end

  assign fb    = vs_q & ~bus.vs;
  assign found = (bus.center_h != '0 || bus.center_v != '0) &&
                 (32'(bus.center_h) < H_ACTIVE) && (32'(bus.center_v) < V_ACTIVE);

  state_e      state_q, state_d;
  logic        swx_q, swx_d, swc_q, swc_d;
  logic        valid_q, valid_d, loaded_q, loaded_d;
  logic [11:0] track_h_q, track_h_d, track_v_q, track_v_d;
  logic [7:0]  lost_q, lost_d, lost_inc;
  logic [13:0] sum_h, sum_v;
  logic        clr_hit, ext_hit;

  // 3*t + c in 14 bits; >>2 is taken by slicing [13:2].
  assign sum_h    = 14'({track_h_q, 1'b0}) + 14'(track_h_q) + 14'(bus.center_h);
  assign sum_v    = 14'({track_v_q, 1'b0}) + 14'(track_v_q) + 14'(bus.center_v);
  assign lost_inc = (32'(lost_q) >= LOST_FRAMES) ? lost_q : lost_q + 8'd1;
  assign clr_hit  = press[1] && (state_q != StClear);
  assign ext_hit  = press[0] && (state_q == StIdle || state_q == StTrack || state_q == StLost);

  always_comb begin
    state_d   = state_q;
    swx_d     = swx_q;
    swc_d     = swc_q;
    loaded_d  = loaded_q;
    track_h_d = track_h_q;
    track_v_d = track_v_q;
    lost_d    = lost_q;
    if (clr_hit) begin
      state_d = StClear;
      swx_d   = 1'b0;
    end else if (ext_hit) begin
      state_d = StArm;
    end else if (fb) begin
      unique case (state_q)
        StIdle: ;
        StArm: begin
          state_d = StLearn;
          swx_d   = 1'b1;
        end
        StLearn: begin
          state_d  = StTrack;
          swx_d    = 1'b0;
          loaded_d = 1'b0;
          lost_d   = '0;
        end
        StTrack: begin
          if (found) begin
            track_h_d = loaded_q ? sum_h[13:2] : bus.center_h;
            track_v_d = loaded_q ? sum_v[13:2] : bus.center_v;
            loaded_d  = 1'b1;
            lost_d    = '0;
          end else begin
            lost_d = lost_inc;
            if (32'(lost_inc) >= LOST_FRAMES) state_d = StLost;
          end
        end
        StLost: begin
          if (found) begin
            state_d   = StTrack;
            track_h_d = bus.center_h;
            track_v_d = bus.center_v;
            loaded_d  = 1'b1;
            lost_d    = '0;
          end
        end
        StClear: begin
          // First boundary raises sw_clear, the second ends the clear frame.
          if (!swc_q) begin
            swc_d = 1'b1;
          end else begin
            swc_d     = 1'b0;
            state_d   = StIdle;
            track_h_d = '0;
            track_v_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    valid_d = (state_d == StTrack);
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      swx_q     <= 1'b0;
      swc_q     <= 1'b0;
      valid_q   <= 1'b0;
      loaded_q  <= 1'b0;
      track_h_q <= '0;
      track_v_q <= '0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      swx_q     <= swx_d;
      swc_q     <= swc_d;
      valid_q   <= valid_d;
      loaded_q  <= loaded_d;
      track_h_q <= track_h_d;
      track_v_q <= track_v_d;
      lost_q    <= lost_d;
    end
  end

  assign bus.sw_extract  = swx_q;
  assign bus.sw_clear    = swc_q;
  assign bus.track_h     = track_h_q;
  assign bus.track_v     = track_v_q;
  assign bus.track_valid = valid_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_track_ctrl.sv
// Self-checking bench for track_ctrl: directed vector table, hand sequences, random vs model.
module tb_track_ctrl;
  localparam int D  = 16;
  localparam int LF = 8;
  localparam int HA = 1280;
  localparam int VA = 720;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  track_if bus ();

  track_ctrl #(
    .DEBOUNCE_CYC(D),
    .LOST_FRAMES (LF),
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA)
  ) dut (
    .video_clk(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model, updated once per completed press or frame.
  int m_state, m_h, m_v, m_lost;
  bit m_loaded, m_swx, m_swc;

  typedef struct {
    int act;  // 0 frame, 1 extract, 2 clear, 3 both
    int h, v;
    int st, th, tv, sx, sc;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, 32'(bus.state_o), m_state);
    check({tag, ".th"}, 32'(bus.track_h), m_h);
    check({tag, ".tv"}, 32'(bus.track_v), m_v);
    check({tag, ".valid"}, 32'(bus.track_valid), 32'(m_state == 3));
    check({tag, ".swx"}, 32'(bus.sw_extract), 32'(m_swx));
    check({tag, ".swc"}, 32'(bus.sw_clear), 32'(m_swc));
  endtask

  function automatic bit is_found(input int h, input int v);
    return (h != 0 || v != 0) && h < HA && v < VA;
  endfunction

  task automatic model_reset();
    m_state = 0; m_h = 0; m_v = 0; m_lost = 0;
    m_loaded = 0; m_swx = 0; m_swc = 0;
  endtask

  task automatic model_press(input bit e, input bit c);
    if (c && m_state != 5) begin
      m_state = 5;
      m_swx   = 0;
    end else if (e && (m_state == 0 || m_state == 3 || m_state == 4)) begin
      m_state = 1;
    end
  endtask

  task automatic model_frame(input int h, input int v);
    bit f = is_found(h, v);
    case (m_state)
      1: begin m_state = 2; m_swx = 1; end
      2: begin m_state = 3; m_swx = 0; m_loaded = 0; m_lost = 0; end
      3: begin
        if (f) begin
          m_h = m_loaded ? (3 * m_h + h) / 4 : h;
          m_v = m_loaded ? (3 * m_v + v) / 4 : v;
          m_loaded = 1;
          m_lost = 0;
        end else begin
          m_lost = (m_lost + 1 > LF) ? LF : m_lost + 1;
          if (m_lost == LF) m_state = 4;
        end
      end
      4: if (f) begin m_state = 3; m_h = h; m_v = v; m_loaded = 1; m_lost = 0; end
      5: begin
        if (!m_swc) m_swc = 1;
        else begin m_swc = 0; m_state = 0; m_h = 0; m_v = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic press(input bit e, input bit c, input int hold);
    @(negedge clk);
    bus.btn_extract = e;
    bus.btn_clear   = c;
    repeat (hold) @(negedge clk);
    bus.btn_extract = 1'b0;
    bus.btn_clear   = 1'b0;
    repeat (D + 4) @(negedge clk);
    if (hold >= D) model_press(e, c);
  endtask

  task automatic frame(input int h, input int v);
    @(negedge clk);
    bus.center_h = 12'(h);
    bus.center_v = 12'(v);
    bus.vs       = 1'b1;
    @(negedge clk);
    bus.vs = 1'b0;
    repeat (3) @(negedge clk);
    model_frame(h, v);
  endtask

  function automatic void add(input int act, input int h, input int v, input int st,
                              input int th, input int tv, input int sx, input int sc);
    vec_t r;
    r.act = act; r.h = h; r.v = v; r.st = st; r.th = th; r.tv = tv; r.sx = sx; r.sc = sc;
    tbl.push_back(r);
  endfunction

  initial begin
    bus.vs = 1'b0; bus.btn_extract = 1'b0; bus.btn_clear = 1'b0;
    bus.center_h = '0; bus.center_v = '0;
    model_reset();

    // Directed vectors: learn, smoothing, lost/reacquire, clear paths.
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 2, 0, 0, 1, 0);
    add(0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 100, 100, 3, 100, 100, 0, 0);
    add(0, 200, 200, 3, 125, 125, 0, 0);
    add(0, 200, 200, 3, 143, 143, 0, 0);
    add(0, 200, 200, 3, 157, 157, 0, 0);
    add(0, 200, 200, 3, 167, 167, 0, 0);
    add(0, 200, 200, 3, 175, 175, 0, 0);
    for (int i = 0; i < LF - 1; i++) add(0, 0, 0, 3, 175, 175, 0, 0);
    add(0, 0, 0, 4, 175, 175, 0, 0);
    add(0, 1280, 10, 4, 175, 175, 0, 0);
    add(0, 300, 400, 3, 300, 400, 0, 0);
    add(0, 1280, 5, 3, 300, 400, 0, 0);
    add(0, 5, 720, 3, 300, 400, 0, 0);
    add(0, 4, 0, 3, 226, 300, 0, 0);
    add(3, 0, 0, 5, 226, 300, 0, 0);
    add(0, 0, 0, 5, 226, 300, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 5, 0, 0, 0, 0);
    add(0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 2, 0, 0, 1, 0);
    add(2, 0, 0, 5, 0, 0, 0, 0);
    add(0, 0, 0, 5, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      string tag = $sformatf("vec%0d", i);
      if (tbl[i].act == 0) frame(tbl[i].h, tbl[i].v);
      else press(tbl[i].act[0], tbl[i].act[1], 2 * D);
      check({tag, ".state"}, 32'(bus.state_o), tbl[i].st);
      check({tag, ".th"}, 32'(bus.track_h), tbl[i].th);
      check({tag, ".tv"}, 32'(bus.track_v), tbl[i].tv);
      check({tag, ".valid"}, 32'(bus.track_valid), 32'(tbl[i].st == 3));
      check({tag, ".swx"}, 32'(bus.sw_extract), tbl[i].sx);
      check({tag, ".swc"}, 32'(bus.sw_clear), tbl[i].sc);
    end

    // Debounce boundary: D-1 cycles rejected, exactly D cycles accepted.
    press(1'b1, 1'b0, D - 1);
    check_model("glitch");
    press(1'b1, 1'b0, D);
    check_model("exact_d");
    press(1'b0, 1'b1, 2 * D);
    frame(0, 0);
    frame(0, 0);
    check_model("back_idle");

    // Reset in LEARN must drop sw_extract without waiting for a clock edge.
    press(1'b1, 1'b0, 2 * D);
    frame(0, 0);
    check_model("learn");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.swx", 32'(bus.sw_extract), 0);
    check("async_rst.state", 32'(bus.state_o), 0);
    model_reset();
    @(negedge clk);
    check_model("in_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int it = 0; it < 300; it++) begin
      int r = int'($urandom_range(0, 99));
      int h, v;
      if (r < 8)       press(1'b1, 1'b0, 2 * D);
      else if (r < 12) press(1'b0, 1'b1, 2 * D);
      else if (r < 14) press(1'b1, 1'b1, 2 * D);
      else if (r < 16) press(1'b1, 1'b0, D - 1);
      else begin
        case ($urandom_range(0, 3))
          0: begin h = 0; v = 0; end
          1: begin
            h = int'($urandom_range(HA, 4095));
            v = int'($urandom_range(0, 4095));
          end
          default: begin
            h = int'($urandom_range(0, HA - 1));
            v = int'($urandom_range(1, VA - 1));
          end
        endcase
        frame(h, v);
      end
      check_model($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
